// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one ALU, with lock ownership and a registered result path.
// Define ALU_ARBITER_RR_EN for round-robin contention; otherwise fixed priority to r0 with a burst limit.
module alu_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_req,
    input  logic       r1_req,
    input  logic       r0_lock,
    input  logic       r1_lock,
    input  logic [3:0] r0_mode,
    input  logic [3:0] r1_mode,
    input  logic [7:0] r0_op1,
    input  logic [7:0] r0_op2,
    input  logic [7:0] r1_op1,
    input  logic [7:0] r1_op2,
    output logic       r0_gnt,
    output logic       r1_gnt,
    output logic       r0_vld,
    output logic       r1_vld,
    output logic       alu_en,
    output logic [3:0] alu_mode,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    input  logic [7:0] alu_out,
    input  logic [3:0] alu_flags,
    output logic [7:0] res,
    output logic [3:0] res_flags
);

    typedef enum logic {
        SEL_R0 = 1'b0,
        SEL_R1 = 1'b1
    } sel_t;

    sel_t owner;
    logic owner_vld;
    sel_t last_sel;
    sel_t gnt_sel;
    logic gnt_any;
    logic gnt_lock;
    logic owner_req;

`ifndef ALU_ARBITER_RR_EN
    localparam int CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    logic [CW-1:0] burst_cnt;
`endif

    assign owner_req = (owner == SEL_R0) ? r0_req : r1_req;

    // An active owner pre-empts all arbitration; reset suppresses every grant.
    always_comb begin
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (rst_n) begin
            if (owner_vld && owner_req) begin
                r0_gnt = (owner == SEL_R0);
                r1_gnt = (owner == SEL_R1);
            end else if (r0_req && !r1_req) begin
                r0_gnt = 1'b1;
            end else if (r1_req && !r0_req) begin
                r1_gnt = 1'b1;
            end else if (r0_req && r1_req) begin
`ifdef ALU_ARBITER_RR_EN
                if (last_sel == SEL_R0) r1_gnt = 1'b1;
                else                    r0_gnt = 1'b1;
`else
                if (last_sel == SEL_R0 && burst_cnt == CW'(MAX_BURST)) r1_gnt = 1'b1;
                else                                                   r0_gnt = 1'b1;
`endif
            end
        end
    end

    assign gnt_any  = r0_gnt | r1_gnt;
    assign gnt_sel  = r1_gnt ? SEL_R1 : SEL_R0;
    assign gnt_lock = r1_gnt ? r1_lock : (r0_gnt & r0_lock);

    always_comb begin
        alu_en   = gnt_any;
        alu_mode = 4'd0;
        alu_op1  = 8'd0;
        alu_op2  = 8'd0;
        if (r0_gnt) begin
            alu_mode = r0_mode;
            alu_op1  = r0_op1;
            alu_op2  = r0_op2;
        end else if (r1_gnt) begin
            alu_mode = r1_mode;
            alu_op1  = r1_op1;
            alu_op2  = r1_op2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res       <= 8'd0;
            res_flags <= 4'd0;
            r0_vld    <= 1'b0;
            r1_vld    <= 1'b0;
            owner_vld <= 1'b0;
            owner     <= SEL_R0;
            last_sel  <= SEL_R1;
        end else begin
            r0_vld <= r0_gnt;
            r1_vld <= r1_gnt;
            if (gnt_any) begin
                res       <= alu_out;
                res_flags <= alu_flags;
                last_sel  <= gnt_sel;
            end
            // Ownership ends when the owner releases its lock or drops its request.
            if (gnt_any && gnt_lock) begin
                owner_vld <= 1'b1;
                owner     <= gnt_sel;
            end else if (owner_vld && ((gnt_any && gnt_sel == owner) || !owner_req)) begin
                owner_vld <= 1'b0;
            end
        end
    end

`ifndef ALU_ARBITER_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (!gnt_any) begin
            burst_cnt <= '0;
        end else if (gnt_sel != last_sel) begin
            burst_cnt <= CW'(1);
        end else if (burst_cnt != CW'(MAX_BURST)) begin
            burst_cnt <= burst_cnt + CW'(1);
        end
    end
`endif

endmodule
